// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared types and constants for the UART command dispatcher.
//   state_t   : receiver / dispatcher FSM states
//   *_LSB     : bit positions of the fields inside a command byte
//               [1:0] value, [3:2] channel select, [7:4] header
//   hdr_match : compares the header field of a byte against a header value
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      APPLY = 3'd4
   } state_t;

   localparam int VAL_LSB = 0;
   localparam int SEL_LSB = 2;
   localparam int HDR_LSB = 4;
   localparam int FIELD_W = 2;
   localparam int HDR_W   = 4;
   localparam int NUM_CH  = 4;

   function automatic logic hdr_match(input logic [7:0] cmd, input logic [HDR_W-1:0] hdr);
      return cmd[HDR_LSB +: HDR_W] == hdr;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART receiver: 2-FF synchronizer, start/data/stop sequencing and the
// byte shift register.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous UART line, idle high
//   byte_valid out  1-cycle strobe, stop bit sampled high; byte_data valid
//   byte_data  out  received byte (LSB received first)
//   frame_err  out  1-cycle strobe, stop bit sampled low
// byte_valid / frame_err are asserted in the cycle leading up to the stop
// sample edge, so a consumer registering them sees the result at that edge.
// ---------------------------------------------------------------------------
module uart_rx_core
   import uart_cmd_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [1:0]       sync_reg;
   logic             rx_prev_reg;
   logic             rx_sync;
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       bit_cnt_reg, bit_cnt_next;
   logic [7:0]       shift_reg, shift_next;

   assign rx_sync   = sync_reg[1];
   assign byte_data = shift_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg    <= 2'b11;
         rx_prev_reg <= 1'b1;
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
      end else begin
         sync_reg    <= {sync_reg[0], rx};
         // Delayed copy of the synchronized line; tracked in every state so a
         // start bit directly after a stop bit is still seen as a falling edge.
         rx_prev_reg <= rx_sync;
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      byte_valid   = 1'b0;
      frame_err    = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next     = '0;
            bit_cnt_next = '0;
            if (rx_prev_reg && !rx_sync) begin
               state_next = START;
            end
         end
         START: begin
            // Half a bit in, the line must still be low or it was a glitch.
            if (cnt_reg == HALF_LAST) begin
               cnt_next   = '0;
               state_next = rx_sync ? IDLE : DATA;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DATA: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next     = '0;
               shift_next   = {rx_sync, shift_reg[7:1]};
               bit_cnt_next = bit_cnt_reg + 1'b1;
               if (bit_cnt_reg == 3'd7) begin
                  state_next = STOP;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         STOP: begin
            // Leave at mid stop bit so the rest of the bit time is free for
            // the dispatcher and the next start edge.
            if (cnt_reg == BIT_LAST) begin
               cnt_next   = '0;
               state_next = IDLE;
               if (rx_sync) begin
                  byte_valid = 1'b1;
               end else begin
                  frame_err = 1'b1;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: rtl/uart_cmd_demux.sv
// ---------------------------------------------------------------------------
// uart_cmd_demux
// Receives 8N1 command bytes and writes the 2-bit value field into one of
// four held 2-bit channels chosen by the 2-bit select field.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   rx        in   asynchronous UART line, idle high
//   aa..dd    out  channel 0..3 values (held between commands)
//   upd       out  1-cycle strobe, bit n high when channel n is written
//   frame_err out  1-cycle pulse, stop bit sampled low
//   hdr_err   out  1-cycle pulse, well-framed byte with wrong header
// ---------------------------------------------------------------------------
module uart_cmd_demux
   import uart_cmd_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 5208,
   parameter logic [3:0] HEADER       = 4'hA
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [1:0] aa,
   output logic [1:0] bb,
   output logic [1:0] cc,
   output logic [1:0] dd,
   output logic [3:0] upd,
   output logic       frame_err,
   output logic       hdr_err
);

   logic         byte_valid;
   logic [7:0]   byte_data;
   logic         rx_frame_err;

   state_t       state_reg, state_next;
   logic [1:0]   pend_sel_reg, pend_sel_next;
   logic [1:0]   pend_val_reg, pend_val_next;
   logic [1:0]   ch_reg [NUM_CH];
   logic [3:0]   wr_en;
   logic [3:0]   upd_reg;
   logic         frame_err_reg;
   logic         hdr_err_reg, hdr_err_next;

   uart_rx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .frame_err (rx_frame_err)
   );

   // One write enable per channel; only the selected one fires during APPLY.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_wr
         assign wr_en[gi] = (state_reg == APPLY) && (pend_sel_reg == 2'(gi));
      end
   endgenerate

   always_comb begin
      state_next    = state_reg;
      pend_sel_next = pend_sel_reg;
      pend_val_next = pend_val_reg;
      hdr_err_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (byte_valid) begin
               if (hdr_match(byte_data, HEADER)) begin
                  state_next    = APPLY;
                  pend_sel_next = byte_data[SEL_LSB +: FIELD_W];
                  pend_val_next = byte_data[VAL_LSB +: FIELD_W];
               end else begin
                  hdr_err_next = 1'b1;
               end
            end
         end
         APPLY: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         pend_sel_reg  <= '0;
         pend_val_reg  <= '0;
         upd_reg       <= '0;
         frame_err_reg <= 1'b0;
         hdr_err_reg   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            ch_reg[i] <= '0;
         end
      end else begin
         state_reg     <= state_next;
         pend_sel_reg  <= pend_sel_next;
         pend_val_reg  <= pend_val_next;
         upd_reg       <= wr_en;
         frame_err_reg <= rx_frame_err;
         hdr_err_reg   <= hdr_err_next;
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en[i]) begin
               ch_reg[i] <= pend_val_reg;
            end
         end
      end
   end

   assign aa        = ch_reg[0];
   assign bb        = ch_reg[1];
   assign cc        = ch_reg[2];
   assign dd        = ch_reg[3];
   assign upd       = upd_reg;
   assign frame_err = frame_err_reg;
   assign hdr_err   = hdr_err_reg;

endmodule

// File: tb/tb_uart_cmd_demux.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_demux
// Directed bench for uart_cmd_demux with CLKS_PER_BIT = 16. A table of
// command bytes with hand-computed channel values and pulses is applied in a
// loop; glitch and mid-byte reset cases are written out by hand.
// ---------------------------------------------------------------------------
module tb_uart_cmd_demux;

   localparam int CPB = 16;
   localparam int LAT_UPD = 155;   // C -> upd strobe
   localparam int LAT_ERR = 154;   // C -> error pulse

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [1:0] aa, bb, cc, dd;
   logic [3:0] upd;
   logic       frame_err, hdr_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor totals (written only by the monitor process).
   int         cyc       = 0;
   int         upd_tot   = 0;
   logic [3:0] last_upd  = '0;
   int         upd_cyc   = 0;
   int         hdr_tot   = 0;
   int         hdr_cyc   = 0;
   int         ferr_tot  = 0;
   int         ferr_cyc  = 0;
   int         excl_tot  = 0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         gap;
      logic [1:0] ea, eb, ec, ed;
      logic [3:0] eupd;
      int         ehdr;
      int         eferr;
   } vec_t;

   vec_t vecs[7];

   uart_cmd_demux #(
      .CLKS_PER_BIT(CPB),
      .HEADER      (4'hA)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .aa       (aa),
      .bb       (bb),
      .cc       (cc),
      .dd       (dd),
      .upd      (upd),
      .frame_err(frame_err),
      .hdr_err  (hdr_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (upd != 4'b0000) begin
         upd_tot  = upd_tot + 1;
         last_upd = upd;
         upd_cyc  = cyc;
         if ($countones(upd) != 1) excl_tot = excl_tot + 1;
      end
      if (hdr_err) begin
         hdr_tot = hdr_tot + 1;
         hdr_cyc = cyc;
      end
      if (frame_err) begin
         ferr_tot = ferr_tot + 1;
         ferr_cyc = cyc;
      end
      if (int'(upd != 4'b0000) + int'(hdr_err) + int'(frame_err) > 1)
         excl_tot = excl_tot + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   // Called at a negedge; returns C, the first edge that samples rx low.
   task automatic send_byte(input logic [7:0] data, input logic stop, output int c_edge);
      c_edge = cyc + 1;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(data[i]);
      drive_bit(stop);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int c_edge, u0, h0, f0;
      if (v.gap > 0) idle(v.gap);
      u0 = upd_tot;
      h0 = hdr_tot;
      f0 = ferr_tot;
      send_byte(v.data, v.stop, c_edge);
      check("aa", int'(aa), int'(v.ea));
      check("bb", int'(bb), int'(v.eb));
      check("cc", int'(cc), int'(v.ec));
      check("dd", int'(dd), int'(v.ed));
      check("upd_count", upd_tot - u0, (v.eupd != 4'b0000) ? 1 : 0);
      check("hdr_err_count", hdr_tot - h0, v.ehdr);
      check("frame_err_count", ferr_tot - f0, v.eferr);
      if (v.eupd != 4'b0000) begin
         check("upd_value", int'(last_upd), int'(v.eupd));
         check("upd_latency", upd_cyc - c_edge, LAT_UPD);
      end
      if (v.ehdr != 0) check("hdr_err_latency", hdr_cyc - c_edge, LAT_ERR);
      if (v.eferr != 0) check("frame_err_latency", ferr_cyc - c_edge, LAT_ERR);
      $display("vec %0d byte=%02h stop=%0b aa=%0d bb=%0d cc=%0d dd=%0d upd=%04b hdr=%0d ferr=%0d",
               idx, v.data, v.stop, aa, bb, cc, dd, last_upd, hdr_tot - h0, ferr_tot - f0);
   endtask

   initial begin
      int   u0, c_dummy;
      vec_t v;

      //          data   stop gap  aa bb cc dd  upd      hdr ferr
      vecs[0] = '{8'hAB, 1'b1, 0,  2'd0, 2'd0, 2'd3, 2'd0, 4'b0100, 0, 0};
      vecs[1] = '{8'hA6, 1'b1, 0,  2'd0, 2'd2, 2'd3, 2'd0, 4'b0010, 0, 0};
      vecs[2] = '{8'hA9, 1'b1, 0,  2'd0, 2'd2, 2'd1, 2'd0, 4'b0100, 0, 0};
      vecs[3] = '{8'hAF, 1'b1, 0,  2'd0, 2'd2, 2'd1, 2'd3, 4'b1000, 0, 0};
      vecs[4] = '{8'h5B, 1'b1, 10, 2'd0, 2'd2, 2'd1, 2'd3, 4'b0000, 1, 0};
      vecs[5] = '{8'hA7, 1'b0, 10, 2'd0, 2'd2, 2'd1, 2'd3, 4'b0000, 0, 1};
      vecs[6] = '{8'hA7, 1'b1, 20, 2'd0, 2'd3, 2'd1, 2'd3, 4'b0010, 0, 0};

      // Reset and long idle.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      u0 = upd_tot;
      idle(200);
      check("reset_aa", int'(aa), 0);
      check("reset_bb", int'(bb), 0);
      check("reset_cc", int'(cc), 0);
      check("reset_dd", int'(dd), 0);
      check("reset_upd", int'(upd), 0);
      check("reset_errs", int'({frame_err, hdr_err}), 0);
      check("idle_upd_count", upd_tot - u0, 0);
      $display("idle: aa=%0d bb=%0d cc=%0d dd=%0d upd=%04b", aa, bb, cc, dd, upd);

      // Back-to-back commands, header error, framing error and recovery.
      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Short low glitch while idle: no pulses at all.
      idle(10);
      u0 = upd_tot + hdr_tot + ferr_tot;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      idle(40);
      check("glitch_no_pulse", upd_tot + hdr_tot + ferr_tot - u0, 0);
      $display("glitch: pulses=%0d", upd_tot + hdr_tot + ferr_tot - u0);
      v = '{8'hA1, 1'b1, 5, 2'd1, 2'd3, 2'd1, 2'd3, 4'b0001, 0, 0};
      run_vec(7, v);

      // Reset part-way through the data bits of 0xAE.
      idle(10);
      u0 = upd_tot;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'hAE >> i));
      rst = 1'b1;
      @(negedge clk);
      check("midrst_aa", int'(aa), 0);
      check("midrst_bb", int'(bb), 0);
      check("midrst_cc", int'(cc), 0);
      check("midrst_dd", int'(dd), 0);
      check("midrst_upd", int'(upd), 0);
      rst = 1'b0;
      idle(60 + 5 * CPB);
      check("midrst_no_upd", upd_tot - u0, 0);
      $display("midrst: aa=%0d bb=%0d cc=%0d dd=%0d upd_after=%0d", aa, bb, cc, dd, upd_tot - u0);
      v = '{8'hAE, 1'b1, 5, 2'd0, 2'd0, 2'd0, 2'd2, 4'b1000, 0, 0};
      run_vec(8, v);

      idle(20);
      check("exclusive_pulses", excl_tot, 0);
      c_dummy = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_cmd_demux.md
# uart_cmd_demux

Serial command dispatcher for the car's track controller: receives 8N1 UART bytes on one line and routes the 2-bit value field of each valid command to one of four registered 2-bit outputs (`aa`, `bb`, `cc`, `dd`) chosen by a 2-bit select field. It is the inverse of the track 4:1 selector. That selector merges four 2-bit codes onto one output under `sel`. This block takes one serial stream and fans it back out to four held channels, with per-channel update strobes for downstream logic.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per UART bit (50 MHz / 9600 baud); must be ≥ 4.
- `HEADER`, default 4'hA: required value of command byte bits [7:4].
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx`  in  1  asynchronous UART line, idle high.
- `aa`  out  2  channel 0 value (sel = 2'b00).
- `bb`  out  2  channel 1 value (sel = 2'b01).
- `cc`  out  2  channel 2 value (sel = 2'b10).
- `dd`  out  2  channel 3 value (sel = 2'b11).
- `upd`  out  4  one-cycle strobe; bit n is high in the same cycle channel n is written.
- `frame_err`  out  1  one-cycle pulse when the sampled stop bit is 0.
- `hdr_err`  out  1  one-cycle pulse when the byte is well-framed but bits [7:4] ≠ HEADER.

## Operation
- Command byte format, LSB first on the wire: [1:0] value, [3:2] sel, [7:4] header.
- Input path: `rx` passes through a 2-FF synchronizer. Both FFs reset to 1.
- FSM states and transitions:
  - IDLE: stays in IDLE until a falling edge is seen on the synchronized rx (previous sample 1, current 0). Then go to START.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide), then sample rx.
    - rx = 0: go to DATA.
    - rx = 1: treat as a glitch and return to IDLE with no pulse.
  - DATA: sample 8 bits, one every CLKS_PER_BIT cycles, shifting each into bit 7 of the shift register (LSB arrives first). After the 8th bit, go to STOP.
  - STOP: sample once, CLKS_PER_BIT cycles after the last data bit.
    - Stop = 0: pulse `frame_err`. Discard the byte and go to IDLE.
    - Stop = 1 and header matches: go to APPLY.
    - Stop = 1 and header mismatches: pulse `hdr_err`. Discard the byte and go to IDLE.
  - APPLY: one cycle. Write value into the channel selected by sel and raise `upd[sel]`. Go to IDLE.
- Exactly one channel register changes per accepted command. The other three hold their values.
- Outputs are registered and hold their values indefinitely between commands.
- A byte following a framing error is accepted only after rx returns high and then falls again; the falling-edge rule enforces this.
- `rst` asserted in any state: FSM goes to IDLE, counters and shift register clear, and all outputs return to reset values on the next edge. A partially received byte is lost.

## Timing
- Reset values: `aa`, `bb`, `cc`, `dd` = 2'b00; `upd` = 4'b0000; `frame_err` = 0; `hdr_err` = 0.
- Start-edge detection lags the pin by 2 cycles (synchronizer).
- Latency: let C = the first clock edge at which `rx` is sampled low. The output update and `upd` strobe occur at C + 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles. With CLKS_PER_BIT = 16 this is C + 155.
- Error pulses occur at the stop-sample edge, one cycle earlier than an APPLY would.
- `upd`, `frame_err` and `hdr_err` are mutually exclusive and each is exactly 1 cycle wide.
- Back-to-back bytes (stop bit immediately followed by the next start bit) must be accepted. APPLY plus the return to IDLE fit within the remaining half of the stop bit.
- Bit-time counter width: $clog2(CLKS_PER_BIT). It wraps to 0 on each sample.

## Structure
- Package `uart_cmd_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP, APPLY);
  - field position constants: VAL_LSB = 0, SEL_LSB = 2, HDR_LSB = 4.
- One sub-module, `uart_rx_core`, contains the synchronizer, START/DATA/STOP sequencing, and the byte shift register.
  - It emits a one-cycle `byte_valid` with `byte_data[7:0]`, or a one-cycle `frame_err`.
  - The top level performs the header check, the APPLY demultiplexing, and holds the channel registers.

## Test plan
All scenarios use CLKS_PER_BIT = 16.
1. Reset, then idle rx = 1 for 200 cycles → all outputs 0; `upd` never pulses.
2. Send 0xAB, 0xA6, 0xA9, 0xAF back-to-back. Decoded sel/value: 0xAB = sel 2, val 3; 0xA6 = sel 1, val 2; 0xA9 = sel 2, val 1; 0xAF = sel 3, val 3.
   - Expected pulses, in order: `upd` = 4'b0100, 4'b0010, 4'b0100, 4'b1000.
   - Final outputs: `aa` = 0, `bb` = 2, `cc` = 1, `dd` = 3.
   - First strobe at C + 155.
3. Send 0x5B → `hdr_err` pulses once; all channels unchanged; `upd` stays 0.
4. Send 0xA7 with the stop bit driven 0 → `frame_err` pulses once; `bb` unchanged. Then release rx high and send 0xA7 normally → `bb` = 3, `upd` = 4'b0010.
5. Drive a 3-cycle low glitch on rx while idle → no pulses; FSM back in IDLE. A following 0xA1 → `aa` = 1.
6. Assert `rst` midway through the data bits of 0xAE after `dd` = 3 → all outputs 0 next cycle and no `upd` for the aborted byte. A subsequent 0xAE → `dd` = 2.
